// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder sequencer. A single 1-bit full adder (two half adders and an
// OR for the carry) is reused over WIDTH clock cycles to add two WIDTH-bit
// operands, LSB first. The block owns the operand shift registers, the carry
// flip-flop, the bit counter and the start/done handshake.
//
// Optional feature (compile-time macro SERIAL_ADD_SUB_EN):
//   Adds input 'sub'. When sub=1 at start, B is inverted at latch time and the
//   carry flip-flop is loaded with 1, so the result is a - b (cout=1: no borrow).
//
// Parameters:
//   WIDTH  operand/result width, 2..32 (default 8)
//   CNT_W  bit counter width, derived from WIDTH
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   sub    in   subtract select (only with SERIAL_ADD_SUB_EN)
//   start  in   request an operation, sampled only in IDLE
//   abort  in   synchronous cancel of an operation in RUN
//   a, b   in   operands, latched when start is accepted
//   cin    in   carry-in, latched when start is accepted
//   busy   out  high while in RUN
//   done   out  one-cycle pulse, result valid
//   sum    out  result, held until the next accepted start or an abort
//   cout   out  carry out of the MSB
//   ovf    out  signed overflow (carry into MSB XOR carry out of MSB)
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Operand B and carry-in as they are loaded at start
  logic [WIDTH-1:0]   b_load;
  logic               cin_load;

`ifdef SERIAL_ADD_SUB_EN
  // a - b = a + ~b + 1
  always_comb begin
    b_load   = sub ? ~b : b;
    cin_load = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_load   = b;
    cin_load = cin;
  end
`endif

  // Shared 1-bit adder cell: two half adders and an OR for the carry
  logic ha1_s, ha1_c, ha2_s, ha2_c, fa_s, fa_c;

  always_comb begin
    ha1_s = opa_q[0] ^ opb_q[0];
    ha1_c = opa_q[0] & opb_q[0];
    ha2_s = ha1_s ^ carry_q;
    ha2_c = ha1_s & carry_q;
    fa_s  = ha2_s;
    fa_c  = ha1_c | ha2_c;
  end

  // Next-state and datapath logic
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        // start takes priority over abort here; abort has no effect in IDLE
        if (start) begin
          opa_d   = a;
          opb_d   = b_load;
          carry_d = cin_load;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (abort) begin
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          opa_d   = opa_q >> 1;
          opb_d   = opb_q >> 1;
          // Result bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts
          sum_d   = {fa_s, sum_q[WIDTH-1:1]};
          carry_d = fa_c;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            // carry_q is the carry into the MSB on this last bit
            cout_d  = fa_c;
            ovf_d   = carry_q ^ fa_c;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Directed bench for serial_add_ctrl (WIDTH=8). Inputs change on the falling
// edge, outputs are sampled on the falling edge. Subtract vectors run only
// when SERIAL_ADD_SUB_EN is defined.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub;
`endif
  logic       start;
  logic       abort;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int n_tests = 0;
  int n_fail  = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive start for one edge; returns at the falling edge after the accepting edge
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          input logic abort_v);
    @(negedge clk);
    a     = av;
    b     = bv;
    cin   = cv;
    start = 1'b1;
    abort = abort_v;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Counts falling edges until done, starting at index c0; busy must stay high
  task automatic wait_done(input int c0, output int cyc, output logic busy_all);
    cyc      = c0;
    busy_all = 1'b1;
    while (!done && cyc < 20) begin
      if (!busy) busy_all = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic [7:0] es, input logic ec, input logic eo);
    int   cyc;
    logic ball;
    start_op(av, bv, cv, 1'b0);
    wait_done(0, cyc, ball);
    chk({tag, "_lat"},  cyc,  8);
    chk({tag, "_busy"}, ball, 1);
    chk({tag, "_bdn"},  busy, 0);
    chk({tag, "_sum"},  sum,  es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"},  ovf,  eo);
    @(negedge clk);
    chk({tag, "_dpulse"}, done, 0);
  endtask

  initial begin
    int   cyc;
    logic ball;
    logic seen_done;

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum",  sum,  0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf",  ovf,  0);
    rst_n = 1'b1;

    run_op("ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("1234", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

    // start during RUN is ignored
    start_op(8'h0F, 8'h01, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a     = 8'hAA;
    b     = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, cyc, ball);
    chk("ign_lat",  cyc,  8);
    chk("ign_sum",  sum,  8'h10);
    chk("ign_cout", cout, 0);
    repeat (4) @(negedge clk);
    chk("hold_sum",  sum,  8'h10);
    chk("hold_busy", busy, 0);

    // abort after three processed bits: partial sum is non-zero at that point
    start_op(8'hFF, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abt_busy", busy, 0);
    chk("abt_done", done, 0);
    chk("abt_sum",  sum,  0);
    chk("abt_cout", cout, 0);
    chk("abt_ovf",  ovf,  0);
    seen_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("abt_nodone", seen_done, 0);
    run_op("552a", 8'h55, 8'h2A, 1'b0, 8'h7F, 1'b0, 1'b0);

    // asynchronous reset between edges during RUN
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_sum",  sum,  0);
    chk("arst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("arst_nodone", seen_done, 0);

    // start and abort together in IDLE: start wins
    start_op(8'h80, 8'h80, 1'b0, 1'b1);
    chk("sa_busy", busy, 1);
    wait_done(0, cyc, ball);
    chk("8080_lat",  cyc,  8);
    chk("8080_sum",  sum,  8'h00);
    chk("8080_cout", cout, 1);
    chk("8080_ovf",  ovf,  1);
    @(negedge clk);

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    run_op("s0507", 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
    run_op("s8001", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    sub = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
